// File: rtl/dispatch_queue_pkg.sv
// Shared types and RV32 decode constants for the dispatch queue between IF and issue.
package dispatch_queue_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } if_id_packet_t;

    localparam logic [31:0] WFI_INST  = 32'h1050_0073;
    localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPC_STORE = 7'b0100011;

    function automatic logic is_mem_op(input logic [31:0] inst);
        return (inst[6:0] == OPC_LOAD) || (inst[6:0] == OPC_STORE);
    endfunction

    function automatic logic is_wfi(input logic [31:0] inst);
        return inst == WFI_INST;
    endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Fetch-side and issue-side bundle of the dispatch queue.
interface dispatch_queue_if
    import dispatch_queue_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int CRD_W       = $clog2(ISSUE_WIDTH) + 1
);

    // Fetch side: a group (in_valid, contiguous from lane 0) is taken on a cycle where
    // in_ready is high; otherwise the producer holds it. Issue side has no ready: every
    // out_valid lane is consumed that cycle, and the credits bound how many may be raised.
    logic [FETCH_WIDTH-1:0]                in_valid;
    if_id_packet_t [FETCH_WIDTH-1:0]       in_packet;
    logic                                  in_ready;
    logic [CRD_W-1:0]                      rob_credit;
    logic [CRD_W-1:0]                      rs_credit;
    logic [ISSUE_WIDTH-1:0]                out_valid;
    if_id_packet_t [ISSUE_WIDTH-1:0]       out_packet;

    modport master (
        output in_valid, in_packet, rob_credit, rs_credit,
        input  in_ready, out_valid, out_packet
    );

    modport slave (
        input  in_valid, in_packet, rob_credit, rs_credit,
        output in_ready, out_valid, out_packet
    );

endinterface

// File: rtl/dispatch_queue_select.sv
// Release-count selection: truncates the head window by occupancy, credits,
// the per-cycle load/store cap and the first WFI.
module dq_select
    import dispatch_queue_pkg::*;
#(
    parameter int  ISSUE_WIDTH   = 2,
    parameter int  DEPTH         = 8,
    parameter int  MEM_PER_CYCLE = 1,
    localparam int OCC_W         = $clog2(DEPTH) + 1,
    localparam int CRD_W         = $clog2(ISSUE_WIDTH) + 1
) (
    input  logic [ISSUE_WIDTH-1:0][31:0] head_inst_i,
    input  logic [OCC_W-1:0]             occupancy_i,
    input  logic [CRD_W-1:0]             rob_credit_i,
    input  logic [CRD_W-1:0]             rs_credit_i,
    output logic [CRD_W-1:0]             count_o
);

    int   lim;
    int   mem_cnt;
    int   cnt;
    logic stop;

    always_comb begin
        lim = ISSUE_WIDTH;
        if (int'(occupancy_i) < lim) lim = int'(occupancy_i);
        if (int'(rob_credit_i) < lim) lim = int'(rob_credit_i);
        if (int'(rs_credit_i) < lim) lim = int'(rs_credit_i);

        cnt     = 0;
        mem_cnt = 0;
        stop    = 1'b0;
        // A load/store beyond the cap blocks itself; a WFI is released but blocks its successors.
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (!stop && (i < lim)) begin
                if (is_mem_op(head_inst_i[i])) begin
                    if (mem_cnt >= MEM_PER_CYCLE) stop = 1'b1;
                    else mem_cnt = mem_cnt + 1;
                end
                if (!stop) begin
                    cnt = cnt + 1;
                    if (is_wfi(head_inst_i[i])) stop = 1'b1;
                end
            end
        end
        count_o = CRD_W'(cnt);
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: circular buffer between IF and the parallel issue stages,
// with credit-limited release, WFI halt and flush.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int  FETCH_WIDTH   = 2,
    parameter int  ISSUE_WIDTH   = 2,
    parameter int  DEPTH         = 8,
    parameter int  MEM_PER_CYCLE = 1,
    localparam int PTR_W         = $clog2(DEPTH),
    localparam int OCC_W         = PTR_W + 1,
    localparam int CRD_W         = $clog2(ISSUE_WIDTH) + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    dispatch_queue_if.slave  bus,
    output logic [OCC_W-1:0] occupancy_o,
    output logic             halted_o
);

    if_id_packet_t                   entries_q [DEPTH];
    logic [PTR_W-1:0]                head_q, head_d;
    logic [PTR_W-1:0]                tail_q, tail_d;
    logic [OCC_W-1:0]                occ_q, occ_d;
    logic                            halted_q, halted_d;

    logic                            in_ready;
    logic                            enq;
    logic [OCC_W-1:0]                enq_cnt;
    logic                            issue_en;
    logic [CRD_W-1:0]                sel_cnt;
    logic [CRD_W-1:0]                rel_cnt;
    logic                            wfi_rel;
    logic [ISSUE_WIDTH-1:0]          out_valid;
    if_id_packet_t [ISSUE_WIDTH-1:0] head_pkt;
    logic [ISSUE_WIDTH-1:0][31:0]    head_inst;

    always_comb begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            head_pkt[i]  = entries_q[head_q + PTR_W'(i)];
            head_inst[i] = head_pkt[i].inst;
        end
    end

    dq_select #(
        .ISSUE_WIDTH   (ISSUE_WIDTH),
        .DEPTH         (DEPTH),
        .MEM_PER_CYCLE (MEM_PER_CYCLE)
    ) u_select (
        .head_inst_i  (head_inst),
        .occupancy_i  (occ_q),
        .rob_credit_i (bus.rob_credit),
        .rs_credit_i  (bus.rs_credit),
        .count_o      (sel_cnt)
    );

    // Space check uses start-of-cycle occupancy only; a same-cycle release does not help.
    assign in_ready = reset_i && ((DEPTH - int'(occ_q)) >= FETCH_WIDTH);
    assign enq      = in_ready && !flush_i;
    assign issue_en = reset_i && !flush_i && !halted_q;
    assign rel_cnt  = issue_en ? sel_cnt : '0;

    always_comb begin
        enq_cnt = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (bus.in_valid[i]) enq_cnt = enq_cnt + OCC_W'(1);
        end
        if (!enq) enq_cnt = '0;
    end

    always_comb begin
        out_valid = '0;
        wfi_rel   = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            out_valid[i] = CRD_W'(i) < rel_cnt;
            if (out_valid[i] && is_wfi(head_inst[i])) wfi_rel = 1'b1;
        end
    end

    always_comb begin
        tail_d   = tail_q + PTR_W'(enq_cnt);
        head_d   = head_q + PTR_W'(rel_cnt);
        occ_d    = occ_q + enq_cnt - OCC_W'(rel_cnt);
        halted_d = halted_q | wfi_rel;
        if (flush_i) begin
            tail_d   = '0;
            head_d   = '0;
            occ_d    = '0;
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            head_q   <= '0;
            tail_q   <= '0;
            occ_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            occ_q    <= occ_d;
            halted_q <= halted_d;
            assert ((bus.in_valid & (bus.in_valid + FETCH_WIDTH'(1))) == '0);
            assert (int'(bus.rob_credit) <= ISSUE_WIDTH);
            assert (int'(bus.rs_credit) <= ISSUE_WIDTH);
            assert (int'(occ_q) <= DEPTH);
        end
    end

    // Payload storage carries no reset; validity is tracked by the pointers and occupancy.
    always_ff @(posedge clock_i) begin
        if (enq) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (bus.in_valid[i]) entries_q[tail_q + PTR_W'(i)] <= bus.in_packet[i];
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_packet = head_pkt;
    assign occupancy_o    = occ_q;
    assign halted_o       = halted_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue (FETCH_WIDTH=ISSUE_WIDTH=2, DEPTH=8, MEM_PER_CYCLE=1).
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam logic [31:0] ADD_I = 32'h0020_81b3;
    localparam logic [31:0] LW_I  = 32'h0000_a103;
    localparam logic [31:0] SW_I  = 32'h0020_a023;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [3:0] occ;
    logic       halted;
    int         vectors;
    int         miscompares;

    dispatch_queue_if #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2)) bus ();

    dispatch_queue #(
        .FETCH_WIDTH   (2),
        .ISSUE_WIDTH   (2),
        .DEPTH         (8),
        .MEM_PER_CYCLE (1)
    ) dut (
        .clock_i     (clk),
        .reset_i     (rst_n),
        .flush_i     (flush),
        .bus         (bus),
        .occupancy_o (occ),
        .halted_o    (halted)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    function automatic if_id_packet_t mk(input logic [31:0] pc, input logic [31:0] inst);
        if_id_packet_t p;
        p.inst = inst;
        p.pc   = pc;
        p.npc  = pc + 32'd4;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] i0,
                         input logic [31:0] pc1, input logic [31:0] i1);
        bus.in_valid     = v;
        bus.in_packet[0] = mk(pc0, i0);
        bus.in_packet[1] = mk(pc1, i1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.rob_credit = 2'd2;
        bus.rs_credit  = 2'd2;
        drive(2'b11, 32'hF00, ADD_I, 32'hF04, ADD_I);
        step();
        settle();
        vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL reset_out_valid got %b want 00", bus.out_valid); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        vectors++; if (occ !== 4'd0) begin miscompares++; $display("FAIL reset_occ got %0d want 0", occ); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b want 0", halted); end
        rst_n = 1'b1;
        bus.in_valid = 2'b00;
        settle();
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL post_reset_out_valid got %b want 00", bus.out_valid); end
        step();
    endtask

    task automatic test_alu_stream();
        logic [31:0] base;
        for (int g = 0; g < 5; g++) begin
            base = 32'h100 + 32'(8 * g);
            if (g < 4) drive(2'b11, base, ADD_I, base + 32'd4, ADD_I);
            else bus.in_valid = 2'b00;
            settle();
            if (g == 0) begin
                vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL alu_first_out_valid got %b want 00", bus.out_valid); end
            end else begin
                vectors++; if (bus.out_valid !== 2'b11) begin miscompares++; $display("FAIL alu_out_valid g%0d got %b want 11", g, bus.out_valid); end
                vectors++; if (bus.out_packet[0].pc !== base - 32'd8) begin miscompares++; $display("FAIL alu_pc0 g%0d got %h want %h", g, bus.out_packet[0].pc, base - 32'd8); end
                vectors++; if (bus.out_packet[1].pc !== base - 32'd4) begin miscompares++; $display("FAIL alu_pc1 g%0d got %h want %h", g, bus.out_packet[1].pc, base - 32'd4); end
                vectors++; if (occ !== 4'd2) begin miscompares++; $display("FAIL alu_occ g%0d got %0d want 2", g, occ); end
            end
            step();
        end
        settle();
        vectors++; if (occ !== 4'd0) begin miscompares++; $display("FAIL alu_drain_occ got %0d want 0", occ); end
        vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL alu_drain_out_valid got %b want 00", bus.out_valid); end
    endtask

    task automatic test_credit_full();
        logic [31:0] base;
        bus.rob_credit = 2'd0;
        for (int g = 0; g < 4; g++) begin
            base = 32'h200 + 32'(8 * g);
            drive(2'b11, base, ADD_I, base + 32'd4, ADD_I);
            settle();
            vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL credit0_out_valid g%0d got %b want 00", g, bus.out_valid); end
            step();
        end
        drive(2'b11, 32'hDEAD0, ADD_I, 32'hDEAD4, ADD_I);
        settle();
        vectors++; if (occ !== 4'd8) begin miscompares++; $display("FAIL full_occ got %0d want 8", occ); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready got %b want 0", bus.in_ready); end
        vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL full_out_valid got %b want 00", bus.out_valid); end
        step();
        bus.in_valid   = 2'b00;
        bus.rob_credit = 2'd1;
        for (int i = 0; i < 8; i++) begin
            settle();
            vectors++; if (occ !== 4'(8 - i)) begin miscompares++; $display("FAIL credit1_occ i%0d got %0d want %0d", i, occ, 8 - i); end
            vectors++; if (bus.out_valid !== 2'b01) begin miscompares++; $display("FAIL credit1_out_valid i%0d got %b want 01", i, bus.out_valid); end
            vectors++; if (bus.out_packet[0].pc !== 32'h200 + 32'(4 * i)) begin miscompares++; $display("FAIL credit1_pc i%0d got %h want %h", i, bus.out_packet[0].pc, 32'h200 + 32'(4 * i)); end
            step();
        end
        settle();
        vectors++; if (occ !== 4'd0) begin miscompares++; $display("FAIL credit_drain_occ got %0d want 0", occ); end
        bus.rob_credit = 2'd2;
    endtask

    task automatic test_mem_cap();
        drive(2'b11, 32'h300, LW_I, 32'h304, SW_I);
        settle();
        vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL mem_c0_out_valid got %b want 00", bus.out_valid); end
        step();
        bus.in_valid = 2'b00;
        settle();
        vectors++; if (bus.out_valid !== 2'b01) begin miscompares++; $display("FAIL mem_lw_out_valid got %b want 01", bus.out_valid); end
        vectors++; if (bus.out_packet[0].pc !== 32'h300) begin miscompares++; $display("FAIL mem_lw_pc got %h want 300", bus.out_packet[0].pc); end
        step();
        settle();
        vectors++; if (bus.out_valid !== 2'b01) begin miscompares++; $display("FAIL mem_sw_out_valid got %b want 01", bus.out_valid); end
        vectors++; if (bus.out_packet[0].pc !== 32'h304) begin miscompares++; $display("FAIL mem_sw_pc got %h want 304", bus.out_packet[0].pc); end
        step();
        drive(2'b11, 32'h308, ADD_I, 32'h30C, LW_I);
        settle();
        vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL mem_empty_out_valid got %b want 00", bus.out_valid); end
        step();
        bus.in_valid = 2'b00;
        settle();
        vectors++; if (bus.out_valid !== 2'b11) begin miscompares++; $display("FAIL mem_add_lw_out_valid got %b want 11", bus.out_valid); end
        vectors++; if (bus.out_packet[1].pc !== 32'h30C) begin miscompares++; $display("FAIL mem_add_lw_pc1 got %h want 30c", bus.out_packet[1].pc); end
        step();
        settle();
        vectors++; if (occ !== 4'd0) begin miscompares++; $display("FAIL mem_drain_occ got %0d want 0", occ); end
    endtask

    task automatic test_wfi();
        drive(2'b11, 32'h400, ADD_I, 32'h404, WFI_INST);
        settle();
        vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL wfi_c0_out_valid got %b want 00", bus.out_valid); end
        step();
        drive(2'b11, 32'h408, ADD_I, 32'h40C, ADD_I);
        settle();
        vectors++; if (bus.out_valid !== 2'b11) begin miscompares++; $display("FAIL wfi_rel_out_valid got %b want 11", bus.out_valid); end
        vectors++; if (bus.out_packet[1].pc !== 32'h404) begin miscompares++; $display("FAIL wfi_rel_pc1 got %h want 404", bus.out_packet[1].pc); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL wfi_pre_halted got %b want 0", halted); end
        step();
        drive(2'b11, 32'h410, ADD_I, 32'h414, ADD_I);
        settle();
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL wfi_halted got %b want 1", halted); end
        vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL wfi_halted_out_valid got %b want 00", bus.out_valid); end
        vectors++; if (occ !== 4'd2) begin miscompares++; $display("FAIL wfi_occ got %0d want 2", occ); end
        step();
        bus.in_valid = 2'b00;
        settle();
        vectors++; if (occ !== 4'd4) begin miscompares++; $display("FAIL wfi_enq_while_halted_occ got %0d want 4", occ); end
        vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL wfi_still_halted_out_valid got %b want 00", bus.out_valid); end
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        settle();
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL wfi_flush_halted got %b want 0", halted); end
        vectors++; if (occ !== 4'd0) begin miscompares++; $display("FAIL wfi_flush_occ got %0d want 0", occ); end
        step();
        drive(2'b11, 32'h500, WFI_INST, 32'h504, ADD_I);
        step();
        bus.in_valid = 2'b00;
        settle();
        vectors++; if (bus.out_valid !== 2'b01) begin miscompares++; $display("FAIL wfi_lane0_out_valid got %b want 01", bus.out_valid); end
        vectors++; if (bus.out_packet[0].pc !== 32'h500) begin miscompares++; $display("FAIL wfi_lane0_pc got %h want 500", bus.out_packet[0].pc); end
        step();
        settle();
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL wfi_lane0_halted got %b want 1", halted); end
        vectors++; if (occ !== 4'd1) begin miscompares++; $display("FAIL wfi_lane0_occ got %0d want 1", occ); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        settle();
        vectors++; if (occ !== 4'd0) begin miscompares++; $display("FAIL wfi_lane0_flush_occ got %0d want 0", occ); end
        step();
    endtask

    task automatic test_flush();
        logic [31:0] base;
        bus.rob_credit = 2'd0;
        for (int g = 0; g < 3; g++) begin
            base = 32'h700 + 32'(8 * g);
            drive(2'b11, base, ADD_I, base + 32'd4, ADD_I);
            step();
        end
        bus.rob_credit = 2'd2;
        flush = 1'b1;
        drive(2'b11, 32'h7F0, ADD_I, 32'h7F4, ADD_I);
        settle();
        vectors++; if (occ !== 4'd6) begin miscompares++; $display("FAIL flush_pre_occ got %0d want 6", occ); end
        vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL flush_out_valid got %b want 00", bus.out_valid); end
        step();
        flush = 1'b0;
        bus.in_valid = 2'b00;
        settle();
        vectors++; if (occ !== 4'd0) begin miscompares++; $display("FAIL flush_occ got %0d want 0", occ); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL flush_halted got %b want 0", halted); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got %b want 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 2'b00) begin miscompares++; $display("FAIL flush_next_out_valid got %b want 00", bus.out_valid); end
        step();
        drive(2'b11, 32'h800, ADD_I, 32'h804, ADD_I);
        step();
        bus.in_valid = 2'b00;
        settle();
        vectors++; if (bus.out_valid !== 2'b11) begin miscompares++; $display("FAIL flush_after_out_valid got %b want 11", bus.out_valid); end
        vectors++; if (bus.out_packet[0].pc !== 32'h800) begin miscompares++; $display("FAIL flush_after_pc0 got %h want 800", bus.out_packet[0].pc); end
        step();
    endtask

    task automatic test_wrap();
        int          rs_tab [20] = '{2, 0, 1, 2, 1, 0, 0, 2, 1, 2, 2, 1, 0, 0, 2, 2, 1, 0, 2, 2};
        logic [31:0] exp_q [$];
        logic [31:0] next_pc;
        int          m_occ;
        int          exp_n;
        logic        exp_ready;
        logic [1:0]  exp_mask;
        next_pc = 32'h900;
        m_occ   = 0;
        for (int c = 0; c < 20; c++) begin
            rst_n          = (c == 10) ? 1'b0 : 1'b1;
            bus.rob_credit = 2'd2;
            bus.rs_credit  = 2'(rs_tab[c]);
            drive(2'b11, next_pc, ADD_I, next_pc + 32'd4, ADD_I);
            settle();
            if (c == 10) begin
                exp_ready = 1'b0;
                exp_n     = 0;
            end else begin
                exp_ready = (8 - m_occ) >= 2;
                exp_n     = (m_occ < 2) ? m_occ : 2;
                if (rs_tab[c] < exp_n) exp_n = rs_tab[c];
            end
            exp_mask = (exp_n == 0) ? 2'b00 : (exp_n == 1) ? 2'b01 : 2'b11;
            vectors++; if (occ !== 4'(m_occ)) begin miscompares++; $display("FAIL wrap_occ c%0d got %0d want %0d", c, occ, m_occ); end
            vectors++; if (bus.in_ready !== exp_ready) begin miscompares++; $display("FAIL wrap_in_ready c%0d got %b want %b", c, bus.in_ready, exp_ready); end
            vectors++; if (bus.out_valid !== exp_mask) begin miscompares++; $display("FAIL wrap_out_valid c%0d got %b want %b", c, bus.out_valid, exp_mask); end
            for (int i = 0; i < exp_n; i++) begin
                vectors++; if (bus.out_packet[i].pc !== exp_q[i]) begin miscompares++; $display("FAIL wrap_pc c%0d lane%0d got %h want %h", c, i, bus.out_packet[i].pc, exp_q[i]); end
            end
            if (c == 10) begin
                exp_q.delete();
            end else begin
                for (int i = 0; i < exp_n; i++) void'(exp_q.pop_front());
                if (exp_ready) begin
                    exp_q.push_back(next_pc);
                    exp_q.push_back(next_pc + 32'd4);
                    next_pc = next_pc + 32'd8;
                end
            end
            m_occ = exp_q.size();
            step();
        end
        rst_n = 1'b1;
        bus.in_valid = 2'b00;
        settle();
        vectors++; if (occ !== 4'(m_occ)) begin miscompares++; $display("FAIL wrap_end_occ got %0d want %0d", occ, m_occ); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL wrap_end_halted got %b want 0", halted); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_alu_stream();
        test_credit_full();
        test_mem_cap();
        test_wfi();
        test_flush();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
